// File: rtl/lsu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_issue_arbiter
//
// Purpose:
//   Collects up to two memory micro-ops per cycle from the two issue lanes
//   (lane 0 older than lane 1) into a small in-order queue, and presents the
//   queue head to the single LSU request port. Issue is held whenever the
//   queue could not absorb a full dual-issue bundle. A one-entry writeback
//   stage follows each dispatched load and emits its destination register
//   one cycle later.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               drop every queued op and the pending writeback
//   i_laneN_*             lane N op: valid, operator, base, immediate,
//                         store data, load destination
//   o_issue_stall         issue stage must hold both lanes
//   o_lsu_valid/_*        queue head presented to the LSU
//   i_lsu_ready           LSU accepts the head this cycle
//   o_wb_valid/_rd_addr   load result available at the LSU this cycle
//   o_count               queue occupancy
// ---------------------------------------------------------------------------
package lsu_issue_arbiter_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    SRL  = 4'd5,
    SRA  = 4'd6,
    LB   = 4'd7,
    LH   = 4'd8,
    LW   = 4'd9,
    LBU  = 4'd10,
    LHU  = 4'd11,
    SB   = 4'd12,
    SH   = 4'd13,
    SW   = 4'd14
  } operator_e;

  function automatic logic is_load_op(operator_e op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_mem_op(operator_e op);
    return is_load_op(op) || (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

module lsu_issue_arbiter
  import lsu_issue_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LSU_ADDR_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_lane0_valid,
  input  operator_e               i_lane0_instr,
  input  logic [LSU_ADDR_W-1:0]   i_lane0_op_a,
  input  logic [LSU_ADDR_W-1:0]   i_lane0_op_b,
  input  logic [31:0]             i_lane0_wdata,
  input  logic [4:0]              i_lane0_rd_addr,
  input  logic                    i_lane1_valid,
  input  operator_e               i_lane1_instr,
  input  logic [LSU_ADDR_W-1:0]   i_lane1_op_a,
  input  logic [LSU_ADDR_W-1:0]   i_lane1_op_b,
  input  logic [31:0]             i_lane1_wdata,
  input  logic [4:0]              i_lane1_rd_addr,
  output logic                    o_issue_stall,
  output logic                    o_lsu_valid,
  input  logic                    i_lsu_ready,
  output operator_e               o_lsu_instr,
  output logic [LSU_ADDR_W-1:0]   o_lsu_op_a,
  output logic [LSU_ADDR_W-1:0]   o_lsu_op_b,
  output logic [31:0]             o_lsu_wdata,
  output logic [4:0]              o_lsu_rd_addr,
  output logic                    o_wb_valid,
  output logic [4:0]              o_wb_rd_addr,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    operator_e             instr;
    logic [LSU_ADDR_W-1:0] op_a;
    logic [LSU_ADDR_W-1:0] op_b;
    logic [31:0]           wdata;
    logic [4:0]            rd_addr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;

  logic            enq0, enq1, deq;
  entry_t          head, lane0_e, lane1_e;

  // Issue-side qualification and LSU-side presentation. The stall depends
  // only on the registered count so the issue stage sees a clean timing path.
  // Head fields are zeroed while empty so stale entries never leak out.
  always_comb begin
    lane0_e       = '{instr: i_lane0_instr, op_a: i_lane0_op_a, op_b: i_lane0_op_b,
                      wdata: i_lane0_wdata, rd_addr: i_lane0_rd_addr};
    lane1_e       = '{instr: i_lane1_instr, op_a: i_lane1_op_a, op_b: i_lane1_op_b,
                      wdata: i_lane1_wdata, rd_addr: i_lane1_rd_addr};
    head          = mem_q[rd_ptr_q];
    o_issue_stall = count_q > CW'(DEPTH - 2);
    enq0          = i_lane0_valid && is_mem_op(i_lane0_instr) && !o_issue_stall && !i_flush;
    enq1          = i_lane1_valid && is_mem_op(i_lane1_instr) && !o_issue_stall && !i_flush;
    o_lsu_valid   = (count_q != '0) && !i_flush;
    deq           = o_lsu_valid && i_lsu_ready;

    o_lsu_instr   = ADD;
    o_lsu_op_a    = '0;
    o_lsu_op_b    = '0;
    o_lsu_wdata   = '0;
    o_lsu_rd_addr = '0;
    if (count_q != '0) begin
      o_lsu_instr   = head.instr;
      o_lsu_op_a    = head.op_a;
      o_lsu_op_b    = head.op_b;
      o_lsu_wdata   = head.wdata;
      o_lsu_rd_addr = head.rd_addr;
    end

    o_wb_valid    = wb_valid_q;
    o_wb_rd_addr  = wb_rd_q;
    o_count       = count_q;
  end

  // Next-state for queue storage, pointers, occupancy and writeback stage.
  // Lane 1 lands directly behind lane 0 when both enqueue, otherwise it takes
  // the first free slot. A flush rewinds the pointers; the writeback stage
  // clears on its own because no dispatch can happen in a flush cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (enq0) begin
      mem_d[wr_ptr_q] = lane0_e;
    end
    if (enq1) begin
      mem_d[enq0 ? wr_ptr_q + PW'(1) : wr_ptr_q] = lane1_e;
    end

    wr_ptr_d = wr_ptr_q + PW'(enq0) + PW'(enq1);
    rd_ptr_d = rd_ptr_q + PW'(deq);
    count_d  = count_q + CW'(enq0) + CW'(enq1) - CW'(deq);

    wb_valid_d = deq && is_load_op(head.instr) && (head.rd_addr != 5'd0);
    wb_rd_d    = wb_valid_d ? head.rd_addr : 5'd0;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  // Queue payload storage; contents are only meaningful below count_q.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // The stall rule must keep the occupancy within the storage.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (count_q <= CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_lsu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_issue_arbiter
//
// Purpose:
//   Self-checking bench for lsu_issue_arbiter. Accepted ops are pushed to a
//   scoreboard queue as they are driven and popped when the DUT dispatches;
//   occupancy, stall and writeback expectations come from that same model.
// ---------------------------------------------------------------------------
module tb_lsu_issue_arbiter;
  import lsu_issue_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  typedef struct packed {
    logic            valid;
    operator_e       instr;
    logic [AW-1:0]   op_a;
    logic [AW-1:0]   op_b;
    logic [31:0]     wdata;
    logic [4:0]      rd;
  } lane_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 l0_valid, l1_valid;
  operator_e            l0_instr, l1_instr;
  logic [AW-1:0]        l0_op_a, l0_op_b, l1_op_a, l1_op_b;
  logic [31:0]          l0_wdata, l1_wdata;
  logic [4:0]           l0_rd, l1_rd;
  logic                 issue_stall;
  logic                 lsu_valid;
  logic                 lsu_ready;
  operator_e            lsu_instr;
  logic [AW-1:0]        lsu_op_a, lsu_op_b;
  logic [31:0]          lsu_wdata;
  logic [4:0]           lsu_rd;
  logic                 wb_valid;
  logic [4:0]           wb_rd;
  logic [$clog2(DEPTH):0] count;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  lsu_issue_arbiter #(.DEPTH(DEPTH), .LSU_ADDR_W(AW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .i_lane0_valid   (l0_valid),
    .i_lane0_instr   (l0_instr),
    .i_lane0_op_a    (l0_op_a),
    .i_lane0_op_b    (l0_op_b),
    .i_lane0_wdata   (l0_wdata),
    .i_lane0_rd_addr (l0_rd),
    .i_lane1_valid   (l1_valid),
    .i_lane1_instr   (l1_instr),
    .i_lane1_op_a    (l1_op_a),
    .i_lane1_op_b    (l1_op_b),
    .i_lane1_wdata   (l1_wdata),
    .i_lane1_rd_addr (l1_rd),
    .o_issue_stall   (issue_stall),
    .o_lsu_valid     (lsu_valid),
    .i_lsu_ready     (lsu_ready),
    .o_lsu_instr     (lsu_instr),
    .o_lsu_op_a      (lsu_op_a),
    .o_lsu_op_b      (lsu_op_b),
    .o_lsu_wdata     (lsu_wdata),
    .o_lsu_rd_addr   (lsu_rd),
    .o_wb_valid      (wb_valid),
    .o_wb_rd_addr    (wb_rd),
    .o_count         (count)
  );

  lane_t      sb_q[$];
  logic       wb_valid_m;
  logic [4:0] wb_rd_m;
  int         checks;
  int         errors;
  lane_t      idle;

  function automatic bit isLoad(operator_e op);
    return op inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic bit isMemOp(operator_e op);
    return isLoad(op) || (op inside {SB, SH, SW});
  endfunction

  function automatic lane_t mk(bit v, operator_e op, logic [31:0] a, logic [31:0] b,
                               logic [31:0] wd, logic [4:0] rd);
    lane_t l;
    l.valid = v; l.instr = op; l.op_a = a; l.op_b = b; l.wdata = wd; l.rd = rd;
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, compare every output
  // against the model, then advance the model to match the coming edge.
  task automatic applyStimulus(input lane_t a, input lane_t b, input logic ready, input logic fl);
    bit    stall_m;
    bit    exp_valid;
    lane_t head;
    @(negedge clk);
    l0_valid = a.valid; l0_instr = a.instr; l0_op_a = a.op_a; l0_op_b = a.op_b;
    l0_wdata = a.wdata; l0_rd = a.rd;
    l1_valid = b.valid; l1_instr = b.instr; l1_op_a = b.op_a; l1_op_b = b.op_b;
    l1_wdata = b.wdata; l1_rd = b.rd;
    lsu_ready = ready;
    flush     = fl;
    #1;
    stall_m   = sb_q.size() > DEPTH - 2;
    exp_valid = (sb_q.size() != 0) && !fl;
    checkOutput("count", 64'(count), 64'(sb_q.size()));
    checkOutput("issue_stall", 64'(issue_stall), 64'(stall_m));
    checkOutput("lsu_valid", 64'(lsu_valid), 64'(exp_valid));
    if (exp_valid) begin
      head = sb_q[0];
      checkOutput("lsu_instr", 64'(lsu_instr), 64'(head.instr));
      checkOutput("lsu_op_a", 64'(lsu_op_a), 64'(head.op_a));
      checkOutput("lsu_op_b", 64'(lsu_op_b), 64'(head.op_b));
      checkOutput("lsu_wdata", 64'(lsu_wdata), 64'(head.wdata));
      checkOutput("lsu_rd", 64'(lsu_rd), 64'(head.rd));
    end
    checkOutput("wb_valid", 64'(wb_valid), 64'(wb_valid_m));
    if (wb_valid_m) checkOutput("wb_rd", 64'(wb_rd), 64'(wb_rd_m));

    wb_valid_m = 1'b0;
    if (exp_valid && ready) begin
      head       = sb_q.pop_front();
      wb_valid_m = isLoad(head.instr) && (head.rd != 5'd0);
      wb_rd_m    = head.rd;
    end
    if (fl) begin
      sb_q.delete();
    end else if (!stall_m) begin
      if (a.valid && isMemOp(a.instr)) sb_q.push_back(a);
      if (b.valid && isMemOp(b.instr)) sb_q.push_back(b);
    end
  endtask

  // Hold reset across one rising edge and check every output is cleared.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; lsu_ready = 1'b0;
    l0_valid = 1'b0; l1_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_stall", 64'(issue_stall), 64'd0);
    checkOutput("rst_lsu_valid", 64'(lsu_valid), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wb_rd", 64'(wb_rd), 64'd0);
    checkOutput("rst_instr", 64'(lsu_instr), 64'(ADD));
    checkOutput("rst_op_a", 64'(lsu_op_a), 64'd0);
    rst = 1'b0;
    sb_q.delete();
    wb_valid_m = 1'b0;
    wb_rd_m    = 5'd0;
  endtask

  operator_e mem_ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  function automatic lane_t rndOp();
    return mk(1'b1, mem_ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
              5'($urandom_range(0, 31)));
  endfunction

  initial begin
    bit    accepted;
    bit    rdy;
    lane_t a, b;
    checks = 0; errors = 0;
    idle = mk(1'b0, ADD, 0, 0, 0, 0);
    rst = 1'b1; flush = 1'b0; lsu_ready = 1'b0;
    l0_valid = 1'b0; l0_instr = ADD; l0_op_a = '0; l0_op_b = '0; l0_wdata = '0; l0_rd = '0;
    l1_valid = 1'b0; l1_instr = ADD; l1_op_a = '0; l1_op_b = '0; l1_wdata = '0; l1_rd = '0;
    wb_valid_m = 1'b0; wb_rd_m = 5'd0;

    // Dual issue LW + SW, then drain: count 2,1,0 and writeback rd=5.
    doReset();
    applyStimulus(mk(1, LW, 32'h8000_0000, 4, 0, 5), mk(1, SW, 32'h8000_0010, 8, 32'hCAFE_F00D, 0), 1, 0);
    repeat (3) applyStimulus(idle, idle, 1, 0);

    // LSU blocked, dual LB per cycle: occupancy 2 then 4, third bundle dropped.
    repeat (3) applyStimulus(mk(1, LB, 32'h100, 1, 0, 1), mk(1, LB, 32'h200, 2, 0, 2), 0, 0);
    applyStimulus(idle, idle, 0, 0);
    // One dispatch leaves a writeback pending, then reset mid-operation.
    applyStimulus(idle, idle, 1, 0);
    doReset();
    applyStimulus(idle, idle, 1, 0);

    // Only lane 1 carries a memory op; lane 0 ALU op is ignored.
    applyStimulus(mk(1, ADD, 1, 2, 3, 9), mk(1, LHU, 32'h40, 6, 0, 7), 1, 0);
    repeat (2) applyStimulus(idle, idle, 1, 0);

    // Load to x0 and a store produce no writeback.
    applyStimulus(mk(1, LW, 32'h50, 0, 0, 0), mk(1, SB, 32'h60, 1, 32'hAA, 3), 1, 0);
    repeat (3) applyStimulus(idle, idle, 1, 0);

    // Back-to-back loads give writebacks on consecutive cycles.
    applyStimulus(mk(1, LW, 32'h70, 0, 0, 3), mk(1, LH, 32'h74, 2, 0, 4), 1, 0);
    repeat (3) applyStimulus(idle, idle, 1, 0);

    // Flush with three queued ops and the LSU ready.
    applyStimulus(mk(1, LW, 32'h80, 0, 0, 9), mk(1, LB, 32'h84, 1, 0, 10), 0, 0);
    applyStimulus(mk(1, LH, 32'h88, 2, 0, 11), idle, 0, 0);
    applyStimulus(mk(1, LW, 32'h90, 0, 0, 12), mk(1, SW, 32'h94, 0, 32'h1234, 0), 1, 1);
    repeat (2) applyStimulus(idle, idle, 1, 0);

    // Wrap-around: alternating single/dual bundles, random LSU backpressure.
    // A stalled bundle is re-presented until accepted.
    for (int n = 0; n < 10; n++) begin
      a = rndOp();
      b = (n % 2 == 1) ? rndOp() : idle;
      accepted = 1'b0;
      for (int t = 0; t < 20 && !accepted; t++) begin
        accepted = !(sb_q.size() > DEPTH - 2);
        rdy = (t >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        applyStimulus(a, b, rdy, 0);
      end
      checkOutput("issue_bound", 64'(accepted), 64'd1);
    end
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) begin
      applyStimulus(idle, idle, 1'($urandom_range(0, 1)), 0);
    end
    repeat (2) applyStimulus(idle, idle, 1, 0);
    checkOutput("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_issue_arbiter.md
Name: lsu_issue_arbiter

Overview:
- Merges up to two memory micro-ops per cycle from the two issue lanes onto the single LSU request port. Lane 0 is always older than lane 1.
- A small in-order queue sits between issue and LSU.
- Issue is stalled when the queue cannot take a full dual-issue bundle.
- Tracks the LSU's two-stage load pipeline and produces a writeback tag (rd) one cycle after each load dispatch.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- LSU_ADDR_W, 32, address/operand width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_flush  in  1  pipeline flush; drop all queued ops
- i_lane0_valid  in  1  lane 0 op valid
- i_lane0_instr  in  operator_e  lane 0 operator
- i_lane0_op_a  in  LSU_ADDR_W  base (rs1)
- i_lane0_op_b  in  LSU_ADDR_W  immediate
- i_lane0_wdata  in  32  store data
- i_lane0_rd_addr  in  5  load destination
- i_lane1_*  in  same as lane 0  lane 1 (younger)
- o_issue_stall  out  1  issue must hold both lanes
- o_lsu_valid  out  1  head op presented to LSU
- i_lsu_ready  in  1  LSU accepts op this cycle
- o_lsu_instr  out  operator_e  head operator
- o_lsu_op_a  out  LSU_ADDR_W  head base
- o_lsu_op_b  out  LSU_ADDR_W  head immediate
- o_lsu_wdata  out  32  head store data
- o_lsu_rd_addr  out  5  head rd
- o_wb_valid  out  1  load result valid at LSU p_rdata this cycle
- o_wb_rd_addr  out  5  destination of that load
- o_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- One clock (i_clk). Reset is synchronous, active-high (i_rst). Reset clears rd/wr pointers and count. All outputs are 0 after reset (o_lsu_instr = ADD, o_issue_stall = 0). Reset asserted mid-operation discards queued ops and any pending writeback the next edge.
- Memory op: instr ∈ {LB, LH, LW, LBU, LHU, SB, SH, SW}. A lane enqueues only if valid, is a memory op, and o_issue_stall = 0. Non-memory ops are ignored silently.
- o_issue_stall = (count > DEPTH−2), a pure function of the registered count. While stalled, lane inputs are ignored; the issue stage holds them.
- Enqueue order: lane 0 first, then lane 1, into consecutive slots. If only lane 1 qualifies, it takes the first free slot. Pointers wrap modulo DEPTH.
- o_lsu_valid = (count ≠ 0) && !i_flush. The o_lsu_* fields come from the head entry.
- No same-cycle bypass: minimum enqueue-to-dispatch latency is 1 cycle.
- Dispatch happens when o_lsu_valid && i_lsu_ready; the head is popped at that edge.
- Fields are stable while o_lsu_valid=1 and i_lsu_ready=0.
- Count update: count_next = count + enq_n − deq, with enq_n ∈ {0,1,2}. Simultaneous enqueue of 2 and dequeue of 1 is legal at any non-stalled count. Overflow is impossible by the stall rule; an assertion checks count ≤ DEPTH.
- Writeback: a registered stage captures a dispatched load (LB/LH/LW/LBU/LHU).
  - Next cycle: o_wb_valid=1 and o_wb_rd_addr=rd.
  - Loads with rd_addr=0 give o_wb_valid=0.
  - Stores never produce writeback.
  - Back-to-back load dispatches give o_wb_valid on consecutive cycles.
- Flush (sync, priority below reset):
  - Count and pointers go to 0 and that cycle's enqueues are dropped.
  - o_lsu_valid is forced 0, so no dispatch occurs in the flush cycle.
  - The writeback stage is cleared: o_wb_valid=0 the next cycle, and a writeback already at o_wb_valid in the flush cycle is still output.
- Empty queue with i_lsu_ready=1: no action, o_lsu_valid=0.

Test Plan:
- Reset, then lane0=LW(op_a=0x8000_0000, op_b=4, rd=5) and lane1=SW in the same cycle, i_lsu_ready=1 -> cycle+1: o_lsu_valid=1, instr=LW; cycle+2: SW dispatched, o_wb_valid=1 with rd=5; o_count sequence 2,1,0.
- i_lsu_ready=0, DEPTH=4, dual LB each cycle -> o_count 0→2→4? No: stall asserts at count=3. Second bundle raises count to 4; o_issue_stall=1 from count 3 on; third bundle is ignored; count holds 4.
- Only lane1 valid with LHU(rd=7), lane0 = ADD -> single entry enqueued; dispatched op is LHU; o_wb_rd_addr=7 one cycle after dispatch.
- Load with rd=0 dispatched -> o_wb_valid stays 0. SB dispatched -> o_wb_valid stays 0.
- Queue at 3 entries, head LW dispatching, and i_flush=1 with dual-issue inputs -> o_lsu_valid=0 that cycle; o_count=0 next cycle; no o_wb_valid next cycle.
- Wrap-around: 10 alternating single/dual bundles with random i_lsu_ready -> dispatch order equals issue order (lane0 before lane1); o_lsu_* fields unchanged while stalled by i_lsu_ready=0.
